// File: rtl/regfile_sequencer.sv
// Control stage in front of a 32x32 register bank: one transaction per request, reads before write.
// Optional bus X/Z capture checks are compiled in when REGSEQ_BUS_XCHECK_EN is defined.
module regfile_sequencer #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   rs1_addr,
   input  logic [ADDR_W-1:0]   rs2_addr,
   input  logic [ADDR_W-1:0]   rd_addr,
   input  logic                rd_we,
   input  logic [DATA_W-1:0]   rd_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rs1_data,
   output logic [DATA_W-1:0]   rs2_data,
   output logic [NUM_REGS-1:0] reg_load,
   output logic [DATA_W-1:0]   reg_wdata,
   output logic [NUM_REGS-1:0] reg_out0_en,
   output logic [NUM_REGS-1:0] reg_out1_en,
   input  logic [DATA_W-1:0]   bus0,
   input  logic [DATA_W-1:0]   bus1
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t              state_reg;
   logic [ADDR_W-1:0]   rs1_reg;
   logic [ADDR_W-1:0]   rs2_reg;
   logic [ADDR_W-1:0]   rd_reg;
   logic                we_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [DATA_W-1:0]   rs1_data_reg;
   logic [DATA_W-1:0]   rs2_data_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         rs1_reg      <= '0;
         rs2_reg      <= '0;
         rd_reg       <= '0;
         we_reg       <= 1'b0;
         wdata_reg    <= '0;
         rs1_data_reg <= '0;
         rs2_data_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  rs1_reg   <= rs1_addr;
                  rs2_reg   <= rs2_addr;
                  rd_reg    <= rd_addr;
                  we_reg    <= rd_we;
                  wdata_reg <= rd_data;
                  state_reg <= READ;
               end
            end
            READ: begin
               // Entry 0 is never enabled onto a bus, so its bus value is floating.
               rs1_data_reg <= (rs1_reg == '0) ? '0 : bus0;
               rs2_data_reg <= (rs2_reg == '0) ? '0 : bus1;
               state_reg    <= WRITE;
            end
            WRITE: state_reg <= RESP;
            RESP: begin
               if (rsp_ready)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef REGSEQ_BUS_XCHECK_EN
   always_ff @(posedge clk) begin
      if (reset_n && state_reg == READ) begin
         if (rs1_reg != '0)
            assert (^bus0 !== 1'bx)
               else $error("bus capture fail: rs1=%0d bus=%b", rs1_reg, bus0);
         if (rs2_reg != '0)
            assert (^bus1 !== 1'bx)
               else $error("bus capture fail: rs2=%0d bus=%b", rs2_reg, bus1);
      end
      if (reset_n && state_reg == WRITE && reg_load != '0)
         assert (^reg_wdata !== 1'bx)
            else $error("write data has X/Z bits: %b", reg_wdata);
   end
`endif

   // Strobes are gated by reset_n so an aborted write never reaches the bank's negedge sample.
   logic read_active;
   logic load_active;

   assign read_active = reset_n && (state_reg == READ);
   assign load_active = reset_n && (state_reg == WRITE) && we_reg && (rd_reg != '0);

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
         if (gi == 0) begin : g_zero
            assign reg_load[gi]    = 1'b0;
            assign reg_out0_en[gi] = 1'b0;
            assign reg_out1_en[gi] = 1'b0;
         end else begin : g_reg
            assign reg_load[gi]    = load_active && (rd_reg == ADDR_W'(gi));
            assign reg_out0_en[gi] = read_active && (rs1_reg == ADDR_W'(gi));
            assign reg_out1_en[gi] = read_active && (rs2_reg == ADDR_W'(gi));
         end
      end
   endgenerate

   assign req_ready = reset_n && (state_reg == IDLE);
   assign rsp_valid = reset_n && (state_reg == RESP);
   assign rs1_data  = rs1_data_reg;
   assign rs2_data  = rs2_data_reg;
   assign reg_wdata = wdata_reg;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural bank on the bus side, transaction-level register model for expectations.
module tb_regfile_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        rd_we;
   logic [31:0] rd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rs1_data, rs2_data;
   logic [31:0] reg_load;
   logic [31:0] reg_wdata;
   logic [31:0] reg_out0_en, reg_out1_en;
   logic [31:0] bus0, bus1;

   int checks = 0;
   int errors = 0;
   int txn_no = 0;

   logic [31:0] ref_regs [32];
   logic [31:0] init_val [32];
   logic [31:0] bank     [32];
   logic        bank_init;

   always #5 clk = ~clk;

   regfile_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rd_addr    (rd_addr),
      .rd_we      (rd_we),
      .rd_data    (rd_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .reg_load   (reg_load),
      .reg_wdata  (reg_wdata),
      .reg_out0_en(reg_out0_en),
      .reg_out1_en(reg_out1_en),
      .bus0       (bus0),
      .bus1       (bus1)
   );

   // Register bank: loads on negedge, drives the shared buses while enabled, floats otherwise.
   always @(negedge clk) begin
      for (int i = 0; i < 32; i++) begin
         if (bank_init)
            bank[i] <= init_val[i];
         else if (reg_load[i])
            bank[i] <= reg_wdata;
      end
   end

   always_comb begin
      bus0 = 'z;
      bus1 = 'z;
      for (int i = 0; i < 32; i++) begin
         if (reg_out0_en[i]) bus0 = bank[i];
         if (reg_out1_en[i]) bus1 = bank[i];
      end
   end

   function automatic logic [31:0] onehot(input logic [4:0] a);
      logic [31:0] one;
      one = 32'd1;
      return (a == 5'd0) ? 32'd0 : (one << a);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: drives the request, checks every phase, updates the model after the reads.
   task automatic drive_txn(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                            input logic we, input logic [31:0] d, input int stall,
                            input logic hold_req);
      logic [31:0] exp1, exp2, exp_load;
      int n;
      exp1     = (a1 == 5'd0) ? 32'd0 : ref_regs[a1];
      exp2     = (a2 == 5'd0) ? 32'd0 : ref_regs[a2];
      exp_load = (we && ad != 5'd0) ? onehot(ad) : 32'd0;
      rs1_addr  = a1;
      rs2_addr  = a2;
      rd_addr   = ad;
      rd_we     = we;
      rd_data   = d;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_wait: got %b required 1 within 20 cycles", req_ready);
      end
      step();
      // READ: scramble request inputs so only latched fields can matter
      req_valid = hold_req;
      rs1_addr  = 5'($urandom);
      rs2_addr  = 5'($urandom);
      rd_addr   = 5'($urandom);
      rd_data   = $urandom;
      checks++;
      if (reg_out0_en !== onehot(a1) || reg_out1_en !== onehot(a2) || reg_load !== 32'd0) begin
         errors++;
         $display("FAIL read_strobes: out0=%h out1=%h load=%h required out0=%h out1=%h load=0",
                  reg_out0_en, reg_out1_en, reg_load, onehot(a1), onehot(a2));
      end
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL read_handshake: req_ready=%b rsp_valid=%b required 0 0", req_ready, rsp_valid);
      end
      step();
      checks++;
      if (reg_load !== exp_load || reg_out0_en !== 32'd0 || reg_out1_en !== 32'd0) begin
         errors++;
         $display("FAIL write_strobes: load=%h out0=%h out1=%h required load=%h out0=0 out1=0",
                  reg_load, reg_out0_en, reg_out1_en, exp_load);
      end
      checks++;
      if (reg_wdata !== d || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL write_data: wdata=%h rsp_valid=%b required wdata=%h rsp_valid=0",
                  reg_wdata, rsp_valid, d);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rs1_data !== exp1 || rs2_data !== exp2) begin
         errors++;
         $display("FAIL response: rsp_valid=%b rs1=%h rs2=%h required 1 rs1=%h rs2=%h",
                  rsp_valid, rs1_data, rs2_data, exp1, exp2);
      end
      for (int s = 0; s < stall; s++) begin
         step();
         checks++;
         if (rsp_valid !== 1'b1 || rs1_data !== exp1 || rs2_data !== exp2 || req_ready !== 1'b0 ||
             reg_load !== 32'd0 || reg_out0_en !== 32'd0 || reg_out1_en !== 32'd0) begin
            errors++;
            $display("FAIL stall: rsp_valid=%b rs1=%h rs2=%h req_ready=%b load=%h out0=%h out1=%h required 1 %h %h 0 0 0 0",
                     rsp_valid, rs1_data, rs2_data, req_ready, reg_load, reg_out0_en, reg_out1_en, exp1, exp2);
         end
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL return_idle: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
      end
      if (we && ad != 5'd0)
         ref_regs[ad] = d;
      txn_no++;
      $display("txn %0d: rs1=%0d rs2=%0d rd=%0d we=%0b wdata=%h stall=%0d -> rs1_data=%h rs2_data=%h",
               txn_no, a1, a2, ad, we, d, stall, rs1_data, rs2_data);
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      bank_init = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      rs1_addr  = '0;
      rs2_addr  = '0;
      rd_addr   = '0;
      rd_we     = 1'b0;
      rd_data   = '0;
      for (int i = 0; i < 32; i++) begin
         init_val[i] = $urandom;
         ref_regs[i] = init_val[i];
      end
      step();
      step();
      bank_init = 1'b0;
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || reg_load !== 32'd0 ||
          reg_out0_en !== 32'd0 || reg_out1_en !== 32'd0) begin
         errors++;
         $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b load=%h out0=%h out1=%h required all 0",
                  req_ready, rsp_valid, reg_load, reg_out0_en, reg_out1_en);
      end
      checks++;
      if (rs1_data !== 32'd0 || rs2_data !== 32'd0 || reg_wdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_data: rs1=%h rs2=%h wdata=%h required 0 0 0", rs1_data, rs2_data, reg_wdata);
      end
      reset_n = 1'b1;
      step();
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_write_read();
      drive_txn(5'd0, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF, 0, 1'b0);
      drive_txn(5'd5, 5'd5, 5'd0, 1'b0, 32'h0, 0, 1'b0);
      checks++;
      if (rs1_data !== 32'hDEADBEEF || rs2_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL x5_readback: rs1=%h rs2=%h required deadbeef deadbeef", rs1_data, rs2_data);
      end
   endtask

   task automatic test_read_before_write();
      drive_txn(5'd0, 5'd0, 5'd7, 1'b1, 32'hA5A5A5A5, 0, 1'b0);
      drive_txn(5'd7, 5'd0, 5'd7, 1'b1, 32'h12345678, 0, 1'b0);
      checks++;
      if (rs1_data !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL pre_write_value: rs1=%h required a5a5a5a5", rs1_data);
      end
      drive_txn(5'd7, 5'd7, 5'd0, 1'b0, 32'h0, 0, 1'b0);
      checks++;
      if (rs1_data !== 32'h12345678) begin
         errors++;
         $display("FAIL post_write_value: rs1=%h required 12345678", rs1_data);
      end
   endtask

   task automatic test_write_x0();
      drive_txn(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF, 0, 1'b0);
      drive_txn(5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 0, 1'b0);
      checks++;
      if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
         errors++;
         $display("FAIL x0_read: rs1=%h rs2=%h required 0 0", rs1_data, rs2_data);
      end
   endtask

   task automatic test_stall();
      drive_txn(5'd5, 5'd7, 5'd9, 1'b1, 32'hCAFEF00D, 5, 1'b1);
      drive_txn(5'd9, 5'd5, 5'd0, 1'b0, 32'h0, 0, 1'b0);
   endtask

   task automatic test_reset_abort();
      logic [31:0] old3;
      old3      = ref_regs[3];
      rs1_addr  = 5'd0;
      rs2_addr  = 5'd0;
      rd_addr   = 5'd3;
      rd_we     = 1'b1;
      rd_data   = ~old3;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      checks++;
      if (reg_load !== onehot(5'd3)) begin
         errors++;
         $display("FAIL abort_setup_load: load=%h required %h", reg_load, onehot(5'd3));
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (reg_load !== 32'd0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_strobe_drop: load=%h req_ready=%b required 0 0", reg_load, req_ready);
      end
      step();
      step();
      checks++;
      if (rsp_valid !== 1'b0 || reg_load !== 32'd0) begin
         errors++;
         $display("FAIL abort_in_reset: rsp_valid=%b load=%h required 0 0", rsp_valid, reg_load);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_release: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
         end
      end
      checks++;
      if (bank[3] !== old3) begin
         errors++;
         $display("FAIL abort_bank_x3: x3=%h required %h", bank[3], old3);
      end
      drive_txn(5'd3, 5'd0, 5'd0, 1'b0, 32'h0, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         logic [4:0] a1, a2, ad;
         a1 = (t % 3 == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         a2 = (t % 4 == 0) ? a1 : 5'($urandom);
         ad = (t % 5 == 0) ? a1 : 5'($urandom);
         drive_txn(a1, a2, ad, 1'($urandom), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
      end
      for (int i = 1; i < 32; i++) begin
         checks++;
         if (bank[i] !== ref_regs[i]) begin
            errors++;
            $display("FAIL bank_final x%0d: got %h required %h", i, bank[i], ref_regs[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_read_before_write();
      test_write_x0();
      test_stall();
      test_reset_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Control stage directly upstream of the 32-entry bank of 32-bit registers.
- Accepts one register-file transaction per request handshake: read rs1/rs2 and optionally write rd.
- Drives the bank's per-register load, data_in, out0_en and out1_en strobes.
- Captures the two shared tri-state read buses and returns the read data through a response handshake.

Parameters:
- NUM_REGS, 32: number of registers in the bank. Must be a power of two. Entry 0 is hardwired zero.
- ADDR_W, 5: register address width; equals log2(NUM_REGS).
- DATA_W, 32: register and bus width.

Ports:
- clk  in  1  system clock; all sequencer state updates on posedge. The bank samples load on negedge, mid-cycle.
- reset_n  in  1  synchronous active-low reset, sampled on posedge clk.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- rs1_addr  in  ADDR_W  first read address.
- rs2_addr  in  ADDR_W  second read address.
- rd_addr  in  ADDR_W  write address.
- rd_we  in  1  write enable for this transaction.
- rd_data  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response.
- rs1_data  out  DATA_W  captured rs1 value.
- rs2_data  out  DATA_W  captured rs2 value.
- reg_load  out  NUM_REGS  one-hot (or zero) load strobes to the bank.
- reg_wdata  out  DATA_W  data to all bank data_in inputs.
- reg_out0_en  out  NUM_REGS  one-hot (or zero) enables for read bus 0.
- reg_out1_en  out  NUM_REGS  one-hot (or zero) enables for read bus 1.
- bus0  in  DATA_W  shared read bus 0, driven by the bank.
- bus1  in  DATA_W  shared read bus 1, driven by the bank.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. All outputs are registered or decoded from state plus latched fields only.
- Reset: while reset_n is low at a posedge, the FSM goes to IDLE and all latched fields, rs1_data, rs2_data and reg_wdata are cleared to 0. req_ready is 0 during reset and 1 from the first cycle after release.
- Reset mid-operation: the transaction is aborted and no response is produced. A write already in WRITE must not be issued in the following cycle; the strobes drop in the same cycle reset is seen.
- IDLE:
  - req_ready=1; all strobes 0; rsp_valid=0.
  - On req_valid&&req_ready at a posedge: latch rs1_addr, rs2_addr, rd_addr, rd_we and rd_data; go to READ.
- READ (1 cycle):
  - reg_out0_en=onehot(rs1), reg_out1_en=onehot(rs2). Address 0 gives an all-zero enable.
  - At the next posedge: rs1_data <= (rs1==0) ? 0 : bus0, and likewise rs2_data from bus1. Go to WRITE.
- WRITE (1 cycle):
  - reg_wdata=latched rd_data.
  - reg_load=onehot(rd) only if rd_we && rd!=0, else all zero.
  - Out enables are 0.
  - Next posedge: go to RESP.
- RESP:
  - rsp_valid=1; rs1_data and rs2_data are held stable.
  - On rsp_ready at a posedge: go to IDLE.
  - Holding rsp_ready low stalls the FSM indefinitely with outputs stable.
- Ordering: reads always precede the write, so rs1==rd or rs2==rd returns the pre-write value.
- rs1==rs2: both buses enable the same register; both outputs carry the same value.
- Latency: request accept edge -> rsp_valid high 3 posedges later. Minimum 4 cycles per transaction; no overlap. req_ready stays low from accept until the cycle after the response handshake.
- Out-of-range addresses cannot occur, since NUM_REGS=2^ADDR_W.
- Invariant: at most one bit of reg_load, reg_out0_en or reg_out1_en set in any cycle. Load and out enables are never both asserted in the same cycle.

Optional Feature:
- Macro: REGSEQ_BUS_XCHECK_EN.
- When defined:
  - At the READ->WRITE capture edge, if the captured address is nonzero and the corresponding bus has any X/Z bit (^bus === 1'bx), issue an immediate assertion that prints "bus capture fail: rsN=<addr> bus=<bits>".
  - In WRITE, assert that reg_wdata has no X/Z bits whenever reg_load is nonzero.
- When undefined: no checks are compiled. Functional behaviour and ports are identical in both cases.

Test Plan:
- Reset, then write x5=0xDEADBEEF (rs1=0, rs2=0) -> rsp_valid 3 cycles after accept, rs1_data=rs2_data=0, reg_load[5] high exactly one cycle.
- Read rs1=5, rs2=5 after the above -> both outputs 0xDEADBEEF; reg_out0_en[5] and reg_out1_en[5] high only in the READ cycle.
- Request rs1=7, rd=7, rd_we=1, rd_data=0x12345678 with x7 previously 0xA5A5A5A5 -> rs1_data=0xA5A5A5A5; a subsequent read of x7 returns 0x12345678.
- Write rd=0, rd_data=0xFFFFFFFF, rd_we=1 -> reg_load stays 0; a later read of rs1=0 returns 0 and no out enable is asserted.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_valid stays 1, data stable, req_ready=0, no new strobes. Release -> IDLE, next request accepted.
- Assert reset_n=0 in the WRITE cycle of a write to x3 -> reg_load drops that cycle, x3 is unchanged, rsp_valid never rises, req_ready=1 after release.
